// File: rtl/sram_pkg.sv
// sram_mp shared types and helpers.
// Byte-merge logic is shared by the write path and the read bypass.
package sram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int BYTE_W = 8;
  localparam int MAX_DW = 1024;
  localparam int MAX_BE = MAX_DW / BYTE_W;

  function automatic int bytes_of(input int dw);
    return dw / BYTE_W;
  endfunction

  // Replace the bytes of old_w selected by be with the bytes of new_w.
  function automatic logic [MAX_DW-1:0] be_merge(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_BE-1:0] be
  );
    logic [MAX_DW-1:0] r;
    r = old_w;
    for (int i = 0; i < MAX_BE; i++) begin
      if (be[i]) r[BYTE_W*i +: BYTE_W] = new_w[BYTE_W*i +: BYTE_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_rd_port.sv
// One registered read port of sram_mp.
// A same-cycle write to the same address is merged in (write-first).
module sram_rd_port
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [DATA_WIDTH-1:0]           mem_word,
  input  logic                            we,
  input  logic [ADDR_WIDTH-1:0]           write_addr,
  input  logic [DATA_WIDTH-1:0]           write_data,
  input  logic [bytes_of(DATA_WIDTH)-1:0] write_be,
  output logic [DATA_WIDTH-1:0]           data,
  output logic                            valid
);

  logic                  hit;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] next_word;

  assign hit = we && (write_addr == addr);

  assign merged = DATA_WIDTH'(be_merge(
    MAX_DW'(mem_word),
    MAX_DW'(write_data),
    MAX_BE'(write_be)
  ));

  assign next_word = hit ? merged : mem_word;

  // Capture the word on an accepted read; hold it otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= en;
      if (en) data <= next_word;
    end
  end

endmodule

// File: rtl/sram_mp.sv
// Multi-port byte-writable SRAM with zero-init sequencer.
// One write port, NUM_RD registered write-first read ports.
module sram_mp
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            we,
  input  logic [ADDR_WIDTH-1:0]           write_addr,
  input  logic [DATA_WIDTH-1:0]           write_data,
  input  logic [bytes_of(DATA_WIDTH)-1:0] write_be,
  input  logic [NUM_RD-1:0]               rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]    read_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]    read_data,
  output logic [NUM_RD-1:0]               read_valid,
  output logic                            ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] ONE  = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  acc;
  logic                  wr_ok;
  logic [NUM_RD-1:0]     rd_ok;
  logic [DATA_WIDTH-1:0] wr_word;

  // Accesses only count in RUN with no clear pending.
  assign acc   = (state == RUN) && !clr && !rst;
  assign wr_ok = acc && we;

  assign wr_word = DATA_WIDTH'(be_merge(
    MAX_DW'(mem[write_addr]),
    MAX_DW'(write_data),
    MAX_BE'(write_be)
  ));

  // Init/run sequencer with registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          cnt <= cnt + ONE;
          if (cnt == LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          if (clr) begin
            state <= INIT;
            cnt   <= '0;
            ready <= 1'b0;
          end
        end
        default: begin
          state <= INIT;
          cnt   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage write: zero fill during INIT, byte-merged user write in RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[cnt[ADDR_WIDTH-1:0]] <= '0;
      end else if (wr_ok) begin
        mem[write_addr] <= wr_word;
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;

    assign addr     = read_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd_ok[p] = acc && rd_en[p];

    sram_rd_port #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_rd (
      .clk        (clk),
      .rst        (rst),
      .en         (rd_ok[p]),
      .addr       (addr),
      .mem_word   (mem[addr]),
      .we         (wr_ok),
      .write_addr (write_addr),
      .write_data (write_data),
      .write_be   (write_be),
      .data       (read_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .valid      (read_valid[p])
    );
  end

endmodule

// File: tb/tb_sram_mp.sv
// Directed bench for sram_mp.
// Inputs change on negedge, outputs sampled on the next negedge.
module tb_sram_mp;
  import sram_pkg::*;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int NR    = 2;
  localparam int DEPTH = 1 << AW;

  logic           clk = 1'b0;
  logic           rst;
  logic           clr;
  logic           we;
  logic [AW-1:0]  write_addr;
  logic [DW-1:0]  write_data;
  logic [3:0]     write_be;
  logic [NR-1:0]  rd_en;
  logic [NR*AW-1:0] read_addr;
  logic [NR*DW-1:0] read_data;
  logic [NR-1:0]  read_valid;
  logic           ready;

  int n_checks = 0;
  int n_errors = 0;

  sram_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .we         (we),
    .write_addr (write_addr),
    .write_data (write_data),
    .write_be   (write_be),
    .rd_en      (rd_en),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .read_valid (read_valid),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd(input int p);
    return read_data[p*DW +: DW];
  endfunction

  task automatic idle();
    clr = 0; we = 0; rd_en = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [3:0] be);
    @(negedge clk);
    we = 1; write_addr = a; write_data = d; write_be = be;
    @(negedge clk);
    we = 0;
  endtask

  task automatic rd2(input logic [1:0] en, input logic [AW-1:0] a0,
                     input logic [AW-1:0] a1);
    @(negedge clk);
    rd_en = en; read_addr = {a1, a0};
    @(negedge clk);
    rd_en = '0;
  endtask

  // Count DEPTH cycles from the current negedge; ready must rise on the last.
  task automatic wait_init(input string tag, input logic [1:0] probe);
    logic seen;
    seen = 1'b0;
    rd_en = probe;
    for (int i = 1; i <= DEPTH; i++) begin
      @(negedge clk);
      seen |= |read_valid;
      if (i == DEPTH - 1) check({tag, "_ready_early"}, 64'(ready), 64'd0);
    end
    rd_en = '0;
    check({tag, "_ready_rise"}, 64'(ready), 64'd1);
    check({tag, "_no_valid_in_init"}, 64'(seen), 64'd0);
  endtask

  initial begin
    rst = 1; idle();
    write_addr = '0; write_data = '0; write_be = '0; read_addr = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_valid", 64'(read_valid), 64'd0);
    check("rst_data", 64'(read_data), 64'd0);
    rst = 0;
    wait_init("init1", 2'b11);

    // Every word reads back zero after init.
    for (int a = 0; a < DEPTH; a++) begin
      rd2(2'b01, AW'(a), '0);
      check("zero_data", 64'(rd(0)), 64'd0);
      check("zero_valid", 64'(read_valid), 64'd1);
    end

    // Byte-enable write.
    wr(5, 32'hDEADBEEF, 4'b1111);
    wr(5, 32'h000000AA, 4'b0001);
    rd2(2'b01, 5, 0);
    check("be_merge", 64'(rd(0)), 64'hDEADBEAA);

    // Write-first bypass, both ports same address.
    @(negedge clk);
    we = 1; write_addr = 9; write_data = 32'h12345678; write_be = 4'hF;
    rd_en = 2'b11; read_addr = {10'd9, 10'd9};
    @(negedge clk);
    idle();
    check("wf_p0", 64'(rd(0)), 64'h12345678);
    check("wf_p1", 64'(rd(1)), 64'h12345678);
    check("wf_valid", 64'(read_valid), 64'd3);

    // Partial-byte bypass merges with the old word.
    @(negedge clk);
    we = 1; write_addr = 9; write_data = 32'h0000AB00; write_be = 4'b0010;
    rd_en = 2'b11; read_addr = {10'd9, 10'd9};
    @(negedge clk);
    idle();
    check("wf_part_p0", 64'(rd(0)), 64'h1234AB78);
    check("wf_part_p1", 64'(rd(1)), 64'h1234AB78);

    // Independent ports, then hold.
    wr(3, 32'h11, 4'hF);
    wr(4, 32'h22, 4'hF);
    rd2(2'b11, 3, 4);
    check("dual_p0", 64'(rd(0)), 64'h11);
    check("dual_p1", 64'(rd(1)), 64'h22);
    check("dual_valid", 64'(read_valid), 64'd3);
    @(negedge clk);
    check("hold_valid", 64'(read_valid), 64'd0);
    check("hold_p0", 64'(rd(0)), 64'h11);
    check("hold_p1", 64'(rd(1)), 64'h22);

    // Clear with a read in the cycle before and a write/read alongside.
    wr(7, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    rd_en = 2'b01; read_addr = {10'd0, 10'd3};
    @(negedge clk);
    check("pre_clr_valid", 64'(read_valid), 64'd1);
    check("pre_clr_data", 64'(rd(0)), 64'h11);
    clr = 1; we = 1; write_addr = 7; write_data = 32'h55555555;
    write_be = 4'hF; rd_en = 2'b01; read_addr = {10'd0, 10'd7};
    @(negedge clk);
    idle();
    check("clr_ready", 64'(ready), 64'd0);
    check("clr_valid", 64'(read_valid), 64'd0);
    check("clr_data_held", 64'(rd(0)), 64'h11);
    wait_init("clr", 2'b01);
    rd2(2'b01, 7, 0);
    check("clr_addr7", 64'(rd(0)), 64'd0);

    // Reset halfway through a re-init.
    wr(DEPTH - 1, 32'h0BADCAFE, 4'hF);
    rd2(2'b10, 0, AW'(DEPTH - 1));
    check("pre_rst_p1", 64'(rd(1)), 64'h0BADCAFE);
    @(negedge clk);
    clr = 1;
    @(negedge clk);
    clr = 0;
    repeat (DEPTH / 2) @(negedge clk);
    rst = 1; rd_en = 2'b11;
    @(negedge clk);
    check("midrst_ready", 64'(ready), 64'd0);
    check("midrst_valid", 64'(read_valid), 64'd0);
    check("midrst_data", 64'(read_data), 64'd0);
    rst = 0;
    wait_init("rst2", 2'b11);
    rd2(2'b11, AW'(DEPTH - 1), 5);
    check("rst2_last", 64'(rd(0)), 64'd0);
    check("rst2_addr5", 64'(rd(1)), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
